// File: rtl/online_div_pkg.sv
// Shared types and digit constants for the online signed-digit divider
// (controller, residual datapath and vector-multiple unit).
`default_nettype none

package online_div_pkg;

  typedef logic [1:0] sd_digit_t;

  localparam sd_digit_t SD_ZERO    = 2'b00;
  localparam sd_digit_t SD_POS     = 2'b10;
  localparam sd_digit_t SD_NEG     = 2'b01;
  localparam sd_digit_t SD_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    RUN     = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/online_div_ctrl.sv
// Sequencing controller for the MSD-first online divider: operand intake,
// online-delay tracking, quotient digit capture and divisor append strobes.
`default_nettype none

module online_div_ctrl
  import online_div_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DELTA      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    x_digit,
  input  logic [1:0]                    d_digit,
  output logic                          vec_load,
  output logic [$clog2(NUM_DIGITS)-1:0] vec_idx,
  input  logic [1:0]                    sel_digit,
  output logic [1:0]                    digit_select,
  output logic [1:0]                    q_digit,
  output logic                          q_valid,
  output logic                          done,
  output logic                          err
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] PRE_LAST   = IW'(DELTA - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] FLUSH_LAST = IW'(DELTA - 1);

  ctrl_state_t state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] flush_q;
  sd_digit_t     q_digit_q;
  sd_digit_t     dsel_q;
  logic          q_valid_q;
  logic          done_q;
  logic          err_q;

  logic      accept;
  logic      step;
  logic      sel_bad;
  sd_digit_t sel_cap;
  logic      operand_bad;

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == PRELOAD) || (state_q == RUN);
  assign accept   = in_valid & in_ready;
  assign vec_load = accept;
  assign vec_idx  = idx_q;

  // Preload accepts fill the online delay; only RUN accepts and FLUSH cycles are steps.
  assign step        = ((state_q == RUN) && accept) || (state_q == FLUSH);
  assign sel_bad     = (sel_digit == SD_ILLEGAL);
  assign sel_cap     = sel_bad ? SD_ZERO : sel_digit;
  assign operand_bad = (x_digit == SD_ILLEGAL) || (d_digit == SD_ILLEGAL);

  assign digit_select = dsel_q;
  assign q_digit      = q_digit_q;
  assign q_valid      = q_valid_q;
  assign done         = done_q;
  assign err          = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      flush_q   <= '0;
      q_digit_q <= SD_ZERO;
      dsel_q    <= SD_ZERO;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;

      if (step) begin
        q_digit_q <= sel_cap;
        dsel_q    <= sel_cap;
        q_valid_q <= 1'b1;
        if (sel_bad) err_q <= 1'b1;
      end
      if (accept && operand_bad) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= PRELOAD;
            idx_q     <= '0;
            flush_q   <= '0;
            q_digit_q <= SD_ZERO;
            dsel_q    <= SD_ZERO;
            err_q     <= 1'b0;
          end
        end
        PRELOAD: begin
          if (accept) begin
            idx_q <= idx_q + IW'(1);
            if (idx_q == PRE_LAST) state_q <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= FLUSH;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            flush_q <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            flush_q <= flush_q + IW'(1);
          end
        end
        DONE: begin
          dsel_q  <= SD_ZERO;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_online_div_ctrl.sv
// Randomized self-checking bench for online_div_ctrl against a per-division
// event model (accept cycles, step cycles, done cycle) built from the digit tables.
`default_nettype none

module tb_online_div_ctrl;

  localparam int N    = 4;
  localparam int D    = 2;
  localparam int IW   = $clog2(N);
  localparam int MAXC = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    x_digit = 2'b00;
  logic [1:0]    d_digit = 2'b00;
  logic          vec_load;
  logic [IW-1:0] vec_idx;
  logic [1:0]    sel_digit = 2'b00;
  logic [1:0]    digit_select;
  logic [1:0]    q_digit;
  logic          q_valid;
  logic          done;
  logic          err;

  online_div_ctrl #(.NUM_DIGITS(N), .DELTA(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_digit(x_digit), .d_digit(d_digit),
    .vec_load(vec_load), .vec_idx(vec_idx),
    .sel_digit(sel_digit), .digit_select(digit_select),
    .q_digit(q_digit), .q_valid(q_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle stimulus for one division; index = cycle number after the start edge.
  bit       iv [MAXC];
  bit [1:0] xd [MAXC];
  bit [1:0] dd [MAXC];
  bit [1:0] sd [MAXC];
  bit       st [MAXC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [1:0] rnd_digit();
    if ($urandom_range(0, 15) == 0) return 2'b11;
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic fill_fixed();
    for (int c = 0; c < MAXC; c++) begin
      iv[c] = 1'b1; xd[c] = 2'b00; dd[c] = 2'b00; sd[c] = 2'b00; st[c] = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < MAXC; c++) begin
      iv[c] = (c > 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      xd[c] = rnd_digit();
      dd[c] = rnd_digit();
      sd[c] = rnd_digit();
      st[c] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic run_div(input int abort_at);
    bit       accept [MAXC];
    bit       step   [MAXC];
    int       acc, last_a, done_c;
    bit [1:0] qexp;
    bit       errexp;
    string    t;

    // Expected event schedule from the division rules.
    for (int c = 0; c < MAXC; c++) begin
      accept[c] = 1'b0; step[c] = 1'b0;
    end
    acc = 0; last_a = 0;
    for (int c = 1; c < MAXC; c++) begin
      if (acc < N && iv[c]) begin
        accept[c] = 1'b1;
        if (acc >= D) step[c] = 1'b1;
        acc++;
        if (acc == N) last_a = c;
      end
    end
    for (int k = 1; k <= D; k++) step[last_a + k] = 1'b1;
    done_c = last_a + D + 1;

    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;

    qexp = 2'b00; errexp = 1'b0; acc = 0;
    for (int c = 1; c <= done_c + 1; c++) begin
      if (c == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 0);
        check("abort digit_select", digit_select, 0);
        check("abort q_digit", q_digit, 0);
        check("abort q_valid", q_valid, 0);
        check("abort done", done, 0);
        check("abort err", err, 0);
        check("abort vec_idx", vec_idx, 0);
        start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort no done", done, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("after abort busy", busy, 0);
        return;
      end

      t = $sformatf("c%0d", c);
      check({"busy ", t}, busy, (c <= done_c));
      check({"in_ready ", t}, in_ready, (c <= last_a));
      check({"q_valid ", t}, q_valid, step[c-1]);
      check({"done ", t}, done, (c == done_c));
      check({"q_digit ", t}, q_digit, qexp);
      check({"digit_select ", t}, digit_select, (c <= done_c) ? qexp : 2'b00);
      check({"err ", t}, err, errexp);

      in_valid  = iv[c];
      x_digit   = xd[c];
      d_digit   = dd[c];
      sel_digit = sd[c];
      start     = (c <= done_c) ? st[c] : 1'b0;
      #1;
      check({"vec_load ", t}, vec_load, (iv[c] && c <= last_a));
      if (c <= last_a) check({"vec_idx ", t}, vec_idx, acc);

      if (accept[c]) begin
        acc++;
        if (xd[c] == 2'b11 || dd[c] == 2'b11) errexp = 1'b1;
      end
      if (step[c]) begin
        qexp = (sd[c] == 2'b11) ? 2'b00 : sd[c];
        if (sd[c] == 2'b11) errexp = 1'b1;
      end

      if (c <= done_c) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    check("reset digit_select", digit_select, 0);
    check("reset q_digit", q_digit, 0);
    check("reset q_valid", q_valid, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset vec_idx", vec_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stall-free reference sequence 10,01,00,10 on steps at cycles 3..6.
    fill_fixed();
    sd[3] = 2'b10; sd[4] = 2'b01; sd[5] = 2'b00; sd[6] = 2'b10;
    run_div(0);
    // One stall cycle in RUN.
    iv[3] = 1'b0;
    sd[3] = 2'b00; sd[4] = 2'b10; sd[5] = 2'b01; sd[6] = 2'b00; sd[7] = 2'b10;
    run_div(0);
    // Illegal selection digit on the second step, then a clean division clears err.
    fill_fixed();
    sd[3] = 2'b10; sd[4] = 2'b11; sd[5] = 2'b01;
    run_div(0);
    fill_fixed();
    run_div(0);
    // Illegal divisor digit at vec_idx 1.
    dd[2] = 2'b11;
    run_div(0);
    // Reset during FLUSH, then a normal division.
    fill_fixed();
    sd[3] = 2'b01; sd[4] = 2'b01;
    run_div(5);
    sd[5] = 2'b10; sd[6] = 2'b01;
    run_div(0);
    // Start while busy is ignored.
    st[3] = 1'b1;
    run_div(0);

    for (int i = 0; i < 40; i++) begin
      fill_random();
      run_div(($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
